bus_responder: RTL

//  Target (slave) end of the VM1 CPU bus: responds to CPU read/write cycles

---
 rtl/bus_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : bus_responder
//  Description : Target end of the VM1 CPU bus. Decodes a RAM window from
//                dba, inserts programmable wait states and answers rd/wt
//                strobes with a registered reply handshake. Backed by an
//                internal word-wide RAM with byte-lane writes.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'o040000,
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] dba,
    input  logic [15:0] dbo,
    input  logic        rd,
    input  logic        wt,
    // Byte-write qualifier; "byte" itself is a reserved word in SystemVerilog.
    input  logic        byte_i,
    output logic [15:0] dbi,
    output logic        reply,
    output logic        sel
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_REPLY = 2'd2;

    localparam int unsigned c_DEPTH = 2 ** ADDR_BITS;

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 is_rd_q, is_rd_d;
    logic                 reply_q, reply_d;
    logic [15:0]          rdata_q;
    logic [15:0]          mem_q [c_DEPTH];

    logic                 w_hit;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_held;
    logic                 w_enter;

    // Window decode is purely on the upper address bits; strobes play no part.
    assign w_hit  = (dba[15:ADDR_BITS+1] == BASE_ADDR[15:ADDR_BITS+1]);
    assign w_idx  = dba[ADDR_BITS:1];
    assign sel    = w_hit;

    // The strobe that opened the cycle must still be asserted to proceed.
    assign w_held = is_rd_q ? rd : wt;

    // Read data is driven only during a read reply so several responders can be ORed.
    assign dbi    = (reply_q && is_rd_q) ? rdata_q : 16'd0;
    assign reply  = reply_q;

    // Handshake FSM next-state logic; w_enter marks the single REPLY-entry edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_rd_d = is_rd_q;
        reply_d = reply_q;
        w_enter = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (w_hit && (rd ^ wt)) begin
                    state_d = c_WAIT;
                    cnt_d   = WAIT_STATES[3:0];
                    is_rd_d = rd;
                end
            end
            c_WAIT: begin
                if (!w_held) begin
                    state_d = c_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = c_REPLY;
                    reply_d = 1'b1;
                    w_enter = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            c_REPLY: begin
                if (!rd && !wt) begin
                    state_d = c_IDLE;
                    reply_d = 1'b0;
                end
            end
            default: begin
                state_d = c_IDLE;
                reply_d = 1'b0;
            end
        endcase
    end

    // Control state: reset wins over ce, ce=0 freezes everything including reply.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_IDLE;
            cnt_q   <= 4'd0;
            is_rd_q <= 1'b0;
            reply_q <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_rd_q <= is_rd_d;
            reply_q <= reply_d;
        end
    end

    // RAM access happens only on REPLY entry; contents survive reset.
    always_ff @(posedge clk) begin
        if (ce && !reset && w_enter) begin
            if (is_rd_q) begin
                rdata_q <= mem_q[w_idx];
            end else if (!byte_i) begin
                mem_q[w_idx] <= dbo;
            end else if (dba[0]) begin
                mem_q[w_idx][15:8] <= dbo[15:8];
            end else begin
                mem_q[w_idx][7:0] <= dbo[7:0];
            end
        end
    end

endmodule
`default_nettype wire
